// File: rtl/cordic_pkg.sv
// Shared fixed-point format, op-mode encoding and core constants for the CORDIC datapath.
package cordic_pkg;

  // Sign-magnitude operands: bit 15 sign, 7 integer bits, 8 fraction bits.
  localparam int FXP_W        = 16;
  localparam int FXP_SIGN_BIT = 15;
  localparam int FXP_INT_W    = 7;
  localparam int FXP_FRAC_W   = 8;

  localparam int CORDIC_LATENCY = 10;

  typedef logic [FXP_W-1:0] fxp_t;

  typedef enum logic {
    OP_ROTATE = 1'b0,
    OP_PHASE  = 1'b1
  } op_mode_e;

  localparam fxp_t FXP_PI      = 16'h0324;
  localparam fxp_t FXP_HALF_PI = 16'h0192;

endpackage

// File: rtl/cordic_result_fifo.sv
// First-word fall-through FIFO holding CORDIC responses; count is exposed for invariant checks.
module cordic_result_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;
  logic             full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid_o    = (count_q != '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign do_pop     = pop_i && valid_o;
  assign pop_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

  // NOTE: the storage array is deliberately not reset; only pointers and count are,
  // and the valid gate on pop_data_o keeps stale words from ever being visible.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Upstream credit flow makes a push into a full FIFO unreachable.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset) push_i |-> !full);

endmodule

// File: rtl/cordic_issue_ctrl.sv
// Valid/ready front end for the pipelined CORDIC core with credit-based issue and an in-order
// response FIFO. Optional saturating statistics counters: define CORDIC_ISSUE_STATS_EN.
module cordic_issue_ctrl
  import cordic_pkg::*;
#(
  parameter  int LATENCY    = CORDIC_LATENCY,
  parameter  int TAG_W      = 4,
  parameter  int FIFO_DEPTH = 16,
  localparam int CRED_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_mode,
  input  logic [FXP_W-1:0] req_x,
  input  logic [FXP_W-1:0] req_y,
  input  logic [FXP_W-1:0] req_angle,
  input  logic [TAG_W-1:0] req_tag,
  output logic             cd_op_mode,
  output logic [FXP_W-1:0] cd_x,
  output logic [FXP_W-1:0] cd_y,
  output logic [FXP_W-1:0] cd_angle,
  input  logic [FXP_W-1:0] cd_res_a,
  input  logic [FXP_W-1:0] cd_res_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_mode,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [FXP_W-1:0] rsp_a,
  output logic [FXP_W-1:0] rsp_b
`ifdef CORDIC_ISSUE_STATS_EN
  ,
  output logic [15:0]      stat_issued,
  output logic [15:0]      stat_retired,
  output logic [15:0]      stat_stall
`endif
);

  typedef struct packed {
    logic             valid;
    op_mode_e         mode;
    logic [TAG_W-1:0] tag;
  } track_t;

  typedef struct packed {
    op_mode_e         mode;
    logic [TAG_W-1:0] tag;
    fxp_t             a;
    fxp_t             b;
  } rsp_t;

  logic [CRED_W-1:0] credits_q;
  logic [CRED_W-1:0] credits_d;
  track_t            track_q [LATENCY];
  track_t            tail;
  rsp_t              cap_entry;
  rsp_t              head_entry;
  logic              accept;
  logic              rsp_pop;
  logic [CRED_W-1:0] rsp_count;

  // Ready comes purely from registered credit state, so it never loops back through req_valid.
  assign req_ready = (credits_q != '0);
  assign accept    = req_valid && req_ready;
  assign rsp_pop   = rsp_valid && rsp_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cd_op_mode = 1'b0;
    cd_x       = '0;
    cd_y       = '0;
    cd_angle   = '0;
    if (accept) begin
      cd_op_mode = req_mode;
      cd_x       = req_x;
      cd_y       = req_y;
      cd_angle   = req_angle;
    end
  end

  always_comb begin
    credits_d = credits_q;
    case ({accept, rsp_pop})
      2'b10:   credits_d = credits_q - CRED_W'(1);
      2'b01:   credits_d = credits_q + CRED_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  // NOTE: combinational next-state uses blocking '=', registered state uses non-blocking '<='.
  always_ff @(posedge clock) begin
    if (reset) credits_q <= CRED_W'(FIFO_DEPTH);
    else       credits_q <= credits_d;
  end

  // Each entry mirrors one core pipeline stage; the valid bit marks slots worth capturing.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) track_q[i] <= '0;
    end else begin
      track_q[0] <= '{valid: accept, mode: op_mode_e'(req_mode), tag: req_tag};
      for (int i = 1; i < LATENCY; i++) track_q[i] <= track_q[i-1];
    end
  end

  assign tail      = track_q[LATENCY-1];
  assign cap_entry = '{mode: tail.mode, tag: tail.tag, a: cd_res_a, b: cd_res_b};

  cordic_result_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (tail.valid),
    .push_data_i (cap_entry),
    .pop_i       (rsp_pop),
    .valid_o     (rsp_valid),
    .pop_data_o  (head_entry),
    .count_o     (rsp_count)
  );

  assign rsp_mode = head_entry.mode;
  assign rsp_tag  = head_entry.tag;
  assign rsp_a    = head_entry.a;
  assign rsp_b    = head_entry.b;

  // Buffered responses plus free credits can never exceed the FIFO size (in-flight ops fill the gap).
  a_credit_bound: assert property (@(posedge clock) disable iff (reset)
    (32'(rsp_count) + 32'(credits_q)) <= 32'(FIFO_DEPTH));

`ifdef CORDIC_ISSUE_STATS_EN
  logic [15:0] stat_issued_q;
  logic [15:0] stat_retired_q;
  logic [15:0] stat_stall_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_issued_q  <= '0;
      stat_retired_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      stat_issued_q  <= sat_inc(stat_issued_q, accept);
      stat_retired_q <= sat_inc(stat_retired_q, rsp_pop);
      stat_stall_q   <= sat_inc(stat_stall_q, req_valid && !req_ready);
    end
  end

  assign stat_issued  = stat_issued_q;
  assign stat_retired = stat_retired_q;
  assign stat_stall   = stat_stall_q;
`endif

endmodule

// File: tb/tb_cordic_issue_ctrl.sv
// Self-checking bench for cordic_issue_ctrl: core stub, credit/scoreboard model, vector table
// and hand-written corner sequences. Stats checks are active when CORDIC_ISSUE_STATS_EN is defined.
module tb_cordic_issue_ctrl;
  import cordic_pkg::*;

  localparam int LAT   = 10;
  localparam int TAG_W = 4;
  localparam int DEPTH = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_mode = 1'b0;
  logic [15:0]      req_x = '0;
  logic [15:0]      req_y = '0;
  logic [15:0]      req_angle = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             cd_op_mode;
  logic [15:0]      cd_x, cd_y, cd_angle;
  logic [15:0]      cd_res_a, cd_res_b;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic             rsp_mode;
  logic [TAG_W-1:0] rsp_tag;
  logic [15:0]      rsp_a, rsp_b;
`ifdef CORDIC_ISSUE_STATS_EN
  logic [15:0]      stat_issued, stat_retired, stat_stall;
`endif

  cordic_issue_ctrl #(.LATENCY(LAT), .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_angle  (req_angle),
    .req_tag    (req_tag),
    .cd_op_mode (cd_op_mode),
    .cd_x       (cd_x),
    .cd_y       (cd_y),
    .cd_angle   (cd_angle),
    .cd_res_a   (cd_res_a),
    .cd_res_b   (cd_res_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_mode   (rsp_mode),
    .rsp_tag    (rsp_tag),
    .rsp_a      (rsp_a),
    .rsp_b      (rsp_b)
`ifdef CORDIC_ISSUE_STATS_EN
    ,
    .stat_issued  (stat_issued),
    .stat_retired (stat_retired),
    .stat_stall   (stat_stall)
`endif
  );

  always #5 clock = ~clock;

  // Core stub: results are the operands delayed by LAT edges.
  logic [15:0] pipe_a [LAT];
  logic [15:0] pipe_b [LAT];
  always_ff @(posedge clock) begin
    pipe_a[0] <= cd_x;
    pipe_b[0] <= cd_y;
    for (int i = 1; i < LAT; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
  end
  assign cd_res_a = pipe_a[LAT-1];
  assign cd_res_b = pipe_b[LAT-1];

  typedef struct {
    int          avail;
    logic        mode;
    logic [3:0]  tag;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  typedef struct {
    logic        valid;
    logic        mode;
    logic [15:0] x, y, ang;
    logic [3:0]  tag;
    logic        e_mode;
    logic [15:0] e_x, e_y, e_ang;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  int   m_credits = DEPTH;
  int   m_issued = 0, m_retired = 0, m_stall = 0;
  logic obs_rsp_valid, obs_req_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic v, input logic m, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] a, input logic [3:0] t);
    req_valid = v; req_mode = m; req_x = x; req_y = y; req_angle = a; req_tag = t;
  endtask

  // One clock cycle: compare outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cycle();
    logic exp_valid, m_acc, m_pop;
    @(negedge clock);
    exp_valid = (sb.size() != 0) && (sb[0].avail <= edge_cnt);
    m_acc = req_valid && (m_credits != 0) && !reset;
    obs_rsp_valid = rsp_valid;
    obs_req_ready = req_ready;
    if (!reset) begin
      check("req_ready", 32'(req_ready), 32'(m_credits != 0));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      check("cd_op_mode", 32'(cd_op_mode), m_acc ? 32'(req_mode) : 32'd0);
      check("cd_x", 32'(cd_x), m_acc ? 32'(req_x) : 32'd0);
      check("cd_y", 32'(cd_y), m_acc ? 32'(req_y) : 32'd0);
      check("cd_angle", 32'(cd_angle), m_acc ? 32'(req_angle) : 32'd0);
      if (exp_valid) begin
        check("rsp_mode", 32'(rsp_mode), 32'(sb[0].mode));
        check("rsp_tag", 32'(rsp_tag), 32'(sb[0].tag));
        check("rsp_a", 32'(rsp_a), 32'(sb[0].a));
        check("rsp_b", 32'(rsp_b), 32'(sb[0].b));
      end
    end
    m_pop = exp_valid && rsp_ready && !reset;
    @(posedge clock);
    edge_cnt++;
    if (reset) begin
      sb.delete();
      m_credits = DEPTH;
      m_issued = 0; m_retired = 0; m_stall = 0;
    end else begin
      if (m_pop) void'(sb.pop_front());
      if (m_acc) sb.push_back('{edge_cnt + LAT, req_mode, req_tag, req_x, req_y});
      m_credits = m_credits + (m_pop ? 1 : 0) - (m_acc ? 1 : 0);
      if (m_acc) m_issued++;
      if (m_pop) m_retired++;
      if (req_valid && (m_credits + (m_acc ? 1 : 0) - (m_pop ? 1 : 0)) == 0) m_stall++;
    end
    #1;
  endtask

  task automatic do_reset();
    set_req(1'b0, 1'b0, '0, '0, '0, '0);
    rsp_ready = 1'b0;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    set_req(1'b0, 1'b0, '0, '0, '0, '0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int   k, first, last, vcount, lows, accs;

    // Reset values
    do_reset();
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_mode", 32'(rsp_mode), 32'd0);
    check("reset rsp_tag", 32'(rsp_tag), 32'd0);
    check("reset rsp_a", 32'(rsp_a), 32'd0);
    check("reset rsp_b", 32'(rsp_b), 32'd0);
    check("reset cd_x", 32'(cd_x), 32'd0);
    check("reset cd_op_mode", 32'(cd_op_mode), 32'd0);
`ifdef CORDIC_ISSUE_STATS_EN
    check("reset stat_issued", 32'(stat_issued), 32'd0);
    check("reset stat_retired", 32'(stat_retired), 32'd0);
    check("reset stat_stall", 32'(stat_stall), 32'd0);
`endif

    // Table-driven issue pass-through
    vt[0] = '{1'b1, OP_ROTATE, 16'h0100, 16'h0000, 16'h00C9,    4'd1,  1'b0, 16'h0100, 16'h0000, 16'h00C9};
    vt[1] = '{1'b1, OP_PHASE,  16'h8123, 16'h0456, FXP_PI,      4'd2,  1'b1, 16'h8123, 16'h0456, 16'h0324};
    vt[2] = '{1'b0, OP_PHASE,  16'h7FFF, 16'hFFFF, 16'h1234,    4'd3,  1'b0, 16'h0000, 16'h0000, 16'h0000};
    vt[3] = '{1'b1, OP_ROTATE, 16'hFFFF, 16'h8000, FXP_HALF_PI, 4'd15, 1'b0, 16'hFFFF, 16'h8000, 16'h0192};
    vt[4] = '{1'b0, OP_ROTATE, 16'h0001, 16'h0002, 16'h0003,    4'd4,  1'b0, 16'h0000, 16'h0000, 16'h0000};
    vt[5] = '{1'b1, OP_PHASE,  16'h0000, 16'h7FFF, 16'h8192,    4'd0,  1'b1, 16'h0000, 16'h7FFF, 16'h8192};
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_req(vt[i].valid, vt[i].mode, vt[i].x, vt[i].y, vt[i].ang, vt[i].tag);
      #1;
      check("vec cd_op_mode", 32'(cd_op_mode), 32'(vt[i].e_mode));
      check("vec cd_x", 32'(cd_x), 32'(vt[i].e_x));
      check("vec cd_y", 32'(cd_y), 32'(vt[i].e_y));
      check("vec cd_angle", 32'(cd_angle), 32'(vt[i].e_ang));
      cycle();
    end
    idle(15);

    // Single rotate: response first visible 11 sampled cycles after the accept cycle, held under backpressure
    rsp_ready = 1'b0;
    set_req(1'b1, OP_ROTATE, 16'h0100, 16'h0000, 16'h00C9, 4'd3);
    cycle();
    set_req(1'b0, 1'b0, '0, '0, '0, '0);
    k = 0;
    for (int n = 1; n <= 30; n++) begin
      cycle();
      if (obs_rsp_valid) begin
        k = n;
        break;
      end
    end
    check("rotate latency", 32'(k), 32'd11);
    idle(2);
    check("rotate hold valid", 32'(rsp_valid), 32'd1);
    check("rotate tag", 32'(rsp_tag), 32'd3);
    check("rotate mode", 32'(rsp_mode), 32'd0);
    check("rotate a", 32'(rsp_a), 32'h0100);
    check("rotate b", 32'(rsp_b), 32'h0000);
    rsp_ready = 1'b1;
    idle(3);

    // Stream 20 with rsp_ready high
    first = -1; last = -1; vcount = 0; lows = 0;
    for (int i = 0; i < 45; i++) begin
      set_req(i < 20, i[0], 16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'(i), 4'(i % 16));
      cycle();
      if (i < 20 && !obs_req_ready) lows++;
      if (obs_rsp_valid) begin
        if (first < 0) first = i;
        last = i;
        vcount++;
      end
    end
    check("stream ready drops", 32'(lows), 32'd0);
    check("stream first rsp", 32'(first), 32'd11);
    check("stream last rsp", 32'(last), 32'd30);
    check("stream rsp count", 32'(vcount), 32'd20);

    // Backpressure: credits run out after 16 accepts
    do_reset();
    accs = 0;
    for (int i = 0; i < 20; i++) begin
      set_req(1'b1, OP_PHASE, 16'h3000 + 16'(i), 16'h4000 + 16'(i), 16'(i), 4'(i % 16));
      cycle();
      if (obs_req_ready) accs++;
      if (i == 16) check("bp ready low 17th", 32'(obs_req_ready), 32'd0);
    end
    check("bp accepts", 32'(accs), 32'd16);
    rsp_ready = 1'b1;
    set_req(1'b1, OP_ROTATE, 16'h5555, 16'h6666, 16'h0001, 4'd9);
    cycle();
    check("bp pop cycle ready", 32'(obs_req_ready), 32'd0);
    rsp_ready = 1'b0;
    cycle();
    check("bp credit return", 32'(obs_req_ready), 32'd1);
    set_req(1'b0, 1'b0, '0, '0, '0, '0);
    cycle();
    check("bp ready after refill", 32'(obs_req_ready), 32'd0);
`ifdef CORDIC_ISSUE_STATS_EN
    check("stat_issued", 32'(stat_issued), 32'd17);
    check("stat_retired", 32'(stat_retired), 32'd1);
    check("stat_stall", 32'(stat_stall), 32'(m_stall));
    check("stat_stall count", 32'(stat_stall), 32'd5);
`endif
    rsp_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (obs_rsp_valid) vcount++;
    end
    check("bp drain count", 32'(vcount), 32'd16);

    // Credits == 1: simultaneous accept and pop keeps ready high
    do_reset();
    for (int i = 0; i < 15; i++) begin
      set_req(1'b1, OP_ROTATE, 16'h0A00 + 16'(i), 16'h0B00 + 16'(i), '0, 4'(i));
      cycle();
    end
    idle(11);
    set_req(1'b1, OP_PHASE, 16'h0C0C, 16'h0D0D, 16'h0E0E, 4'd7);
    rsp_ready = 1'b1;
    cycle();
    check("c1 accept+pop ready", 32'(obs_req_ready), 32'd1);
    rsp_ready = 1'b0;
    idle(1);
    check("c1 ready stays high", 32'(obs_req_ready), 32'd1);
    set_req(1'b1, OP_ROTATE, 16'h0F0F, 16'h0101, 16'h0202, 4'd8);
    cycle();
    idle(1);
    check("c1 last credit used", 32'(obs_req_ready), 32'd0);
    rsp_ready = 1'b1;
    idle(40);

    // Reset with 5 in flight and 3 buffered
    do_reset();
    for (int i = 0; i < 13; i++) begin
      set_req((i < 3) || (i >= 8), OP_PHASE, 16'h7000 + 16'(i), 16'h7100 + 16'(i), '0, 4'(i));
      cycle();
    end
    set_req(1'b0, 1'b0, '0, '0, '0, '0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("midreset rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset req_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (obs_rsp_valid) vcount++;
    end
    check("midreset no responses", 32'(vcount), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cordic_issue_ctrl.md
# cordic_issue_ctrl

Request/response front end for the pipelined CORDIC core. Accepts rotate or phase-calculation requests over a valid/ready handshake, drives the core's operand inputs, and tracks each issued operation through the core's fixed latency with a mode/tag shift register. Captures each result into a response FIFO, so the rest of the datapath sees tagged, back-pressurable, in-order responses instead of a free-running pipeline. Credit-based issue guarantees the FIFO never overflows.

## Interface
- LATENCY, 10: edges from the core sampling its operands to its result ports holding that result.
- TAG_W, 4: request tag width.
- FIFO_DEPTH, 16: response FIFO entries and the total credit count; must be at least LATENCY+1 for full throughput.
- clock  in  1  sole clock; everything is rising-edge.
- reset  in  1  synchronous, active-high; clears all state.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on the edge where req_valid && req_ready.
- req_mode  in  1  0 = rotate, 1 = phase/magnitude.
- req_x, req_y, req_angle  in  16 each  operands, sign-magnitude {sign:7 int:8 frac}.
- req_tag  in  TAG_W  returned unchanged with the response.
- cd_op_mode  out  1  to core op_mode.
- cd_x, cd_y, cd_angle  out  16 each  to core x/y/rotate-amount inputs.
- cd_res_a, cd_res_b  in  16 each  from core x_or_phase_out / y_or_size_out.
- rsp_valid  out  1  FIFO non-empty.
- rsp_ready  in  1  pop on the edge where rsp_valid && rsp_ready.
- rsp_mode  out  1; rsp_tag  out  TAG_W.
- rsp_a, rsp_b  out  16 each  rotate: x', y'; phase: phase, magnitude.

## Operation
- Issue: cd_* outputs are a combinational pass-through of req_*. When the cycle does not accept a request, cd_* are driven to zero with cd_op_mode = 0. Results produced by the core from non-accepted cycles are never captured.
- Credit counter: range 0..FIFO_DEPTH; reset value FIFO_DEPTH.
  - req_ready = (credits != 0). It depends only on registered state, never on req_valid.
  - Accept: credits decrement by 1.
  - Pop: credits increment by 1.
  - Accept and pop on the same edge: credits unchanged.
- Tracking shift register: LATENCY entries of {valid, mode, tag}. On every edge it shifts by one; entry 0 loads {accept, req_mode, req_tag}.
- Capture: on the edge where the tail entry is valid, {tail mode, tail tag, cd_res_a, cd_res_b} is written to the FIFO.
- Response FIFO: first-word fall-through, in order. A push to a full FIFO is impossible by construction; guard it with an assertion.
- Reset mid-operation: the shift register is cleared, the FIFO is emptied, and credits return to FIFO_DEPTH. In-flight core results are discarded because their valid bits are gone.

## Timing
- Reset values: req_ready = 1, rsp_valid = 0, rsp_mode/rsp_tag/rsp_a/rsp_b = 0, cd_* = 0, stat_* = 0.
- Request accepted at edge E → captured at edge E+LATENCY → rsp_valid = 1 in the cycle after E+LATENCY. Accept-to-response latency is LATENCY cycles.
- Throughput is 1 request per cycle sustained when rsp_ready stays high and FIFO_DEPTH ≥ LATENCY+1.
- Credit return: a pop at edge P re-enables req_ready in the cycle after P.
- rsp_* hold stable while rsp_valid && !rsp_ready.

## Configuration
- CORDIC_ISSUE_STATS_EN defined: adds three 16-bit saturating output counters.
  - stat_issued: accepts.
  - stat_retired: pops.
  - stat_stall: cycles with req_valid && !req_ready.
  - All three clear on reset and stop at 0xFFFF.
- CORDIC_ISSUE_STATS_EN undefined: these ports and their logic are absent; all other behaviour is identical.

## Structure
- Shared package cordic_pkg holds:
  - fixed-point width 16 and its sign/int/frac field constants;
  - OP_ROTATE = 0, OP_PHASE = 1;
  - PI = 0x0324, PI/2 = 0x0192;
  - the default core latency 10.
- One sub-module: cordic_result_fifo (parameterised width/depth, FWFT, count output for assertions).

## Test plan
Bench core stub: cd_res_a/cd_res_b = cd_x/cd_y delayed by 10 edges.
- Single rotate: x = 0x0100, y = 0, angle = 0x00C9, tag = 3, accepted at edge 5 → rsp_valid first high after edge 15; rsp_tag = 3, rsp_mode = 0, rsp_a = 0x0100, rsp_b = 0.
- Stream 20 requests (tags 0..15, 0..3) with rsp_ready = 1 → req_ready never drops; 20 responses in order on consecutive cycles starting 10 cycles after the first accept.
- rsp_ready = 0 while streaming 20 requests → exactly 16 accepted and req_ready low from the 17th cycle. Raise rsp_ready for one cycle → one pop, req_ready high the next cycle, one more accept.
- With credits = 1, accept and pop on the same edge → credits stay 1 and req_ready stays high.
- Reset with 5 requests in flight and 3 in the FIFO → next cycle rsp_valid = 0, req_ready = 1; no response appears over the following 20 cycles.
- With CORDIC_ISSUE_STATS_EN, run the backpressure scenario → stat_issued = 17, stat_retired = 1, stat_stall = number of cycles with req_valid && !req_ready.
